mem_traffic_checker: RTL and testbench
======================================

# mem_traffic_checker

Parametrised write-then-readback traffic generator and checker for the DDR2 cache-side command port. It writes DEPTH generated words to an address window, reads them back, and compares them against the regenerated pattern. It repeats for a configurable number of passes, changing the pattern each pass. It reports a sticky error, a saturating mismatch count and the first failing address. It sits in place of the cache as a bring-up and soak-test master on one memory channel.

## Interface
- DATA_W, 256, data bus width; multiple of 32
- ADDR_W, 28, address width
- DEPTH, 9, words per pass; 1..256
- CYCLE_DELAY, 2, idle cycles with valid low after each accepted command; 0 = back-to-back
- BASE_ADDR, 28'h0FF_1000, first address of the window
- ADDR_STRIDE, 8, address increment per word
- MAX_PASSES, 0, passes before stopping; 0 = run until reset
- SEED, 32'h800020C0, pattern seed

Ports:
- clk  in  1  clock; one clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a run; sampled in IDLE and DONE only
- mem_data_wr  out  DATA_W  write data
- mem_data_rd  in  DATA_W  read data; valid in the read-handshake cycle
- mem_data_addr  out  ADDR_W  command address
- mem_rw_data  out  1  1 = write, 0 = read
- mem_valid_data  out  1  command valid
- mem_ready_data  in  1  command accepted; read data returned in the same cycle
- error  out  1  sticky mismatch flag
- err_count  out  16  mismatch count; saturates at 16'hFFFF
- fail_addr  out  ADDR_W  address of the first mismatch
- pass_count  out  16  completed passes; wraps
- done  out  1  high in DONE

## Operation
- States are IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP and DONE.
- IDLE:
  - start moves to WR_REQ and clears idx, pass_count, error, err_count and fail_addr.
- WR_REQ:
  - valid=1, rw=1, addr and data from idx.
  - On handshake (valid & ready), advance idx.
  - Go to WR_GAP if CYCLE_DELAY>0; otherwise go straight to the next request.
  - After the handshake for word DEPTH-1, idx returns to 0 and the next request is RD_REQ.
- RD_REQ:
  - valid=1, rw=0.
  - On handshake, compare mem_data_rd with expected(idx, pass_count).
  - After word DEPTH-1: increment pass_count. Go to DONE if MAX_PASSES≠0 and the new count equals MAX_PASSES; otherwise start the next pass at WR_REQ, idx=0.
- WR_GAP / RD_GAP:
  - valid=0 for exactly CYCLE_DELAY cycles, then enter the pending request state.
- DONE:
  - done=1 and valid=0.
  - start restarts the run exactly as from IDLE.
- Address:
  - BASE_ADDR + idx*ADDR_STRIDE, truncated to ADDR_W bits, so it wraps modulo 2^ADDR_W.
- Pattern:
  - 32-bit lane k = SEED ^ {pass_count[7:0], idx[7:0], k[7:0], 8'hA5}.
  - Computed combinationally; no pattern storage.
- Mismatch:
  - error<=1.
  - err_count increments, saturating.
  - fail_addr is captured only when err_count was 0.
- Ignored inputs:
  - ready while valid=0.
  - start outside IDLE/DONE.
- Reset values:
  - IDLE; all outputs 0 except mem_data_addr=BASE_ADDR.
  - mem_data_wr holds the pattern for idx 0, pass 0.

## Timing
- valid rises the cycle after start is sampled.
- valid, rw, addr and data are stable from the rise of valid through the handshake cycle.
- They change only on the edge that ends the handshake.
- A handshake in the first valid cycle is legal and is accepted.
- Gap length, from handshake edge to next valid rise:
  - CYCLE_DELAY cycles of valid=0 when CYCLE_DELAY>0.
  - With CYCLE_DELAY=0, valid stays high and the next command is presented on the following cycle.
- error, err_count and fail_addr update on the edge ending the read handshake, visible 1 cycle later.
- done rises the cycle after the final read handshake.
- rst in any state: back to IDLE on that edge, valid low next cycle, no further compare.

## Structure
- Package mem_traffic_pkg holds the state enum and pattern lane constant 8'hA5.
- The pattern function is also in the package.
- Sub-module mem_pattern_gen (combinational): inputs idx, pass, SEED; output DATA_W-bit word.
  - Instantiated once and shared between the write data path and the read compare.

## Test plan
- DEPTH=9, CYCLE_DELAY=2, ready tied 1, memory model echoes writes:
  - 9 writes at 0x0FF1000..0x0FF1040 step 8, then 9 reads.
  - Each command followed by 2 valid-low cycles.
  - error stays 0 and pass_count reaches 1.
- MAX_PASSES=3 with the same setup:
  - done rises after the 27th read, with pass_count=3.
  - The pattern differs between passes: lane 0 of idx 0 is SEED^32'h000000A5, then SEED^32'h010000A5, then SEED^32'h020000A5.
- Model corrupts idx 4 read data bit 0:
  - error=1 and err_count=1 one cycle after that read.
  - fail_addr=0x0FF1020.
  - A second corruption at idx 6 gives err_count=2 with fail_addr unchanged.
- CYCLE_DELAY=0, ready low for 5 cycles, then high:
  - Command held stable all 5 cycles.
  - After ready, commands are back to back with valid continuously high.
- BASE_ADDR=28'hFFFFFF8, stride 8, DEPTH=3: addresses FFFFFF8, 0000000, 0000008.
- rst asserted while RD_REQ is waiting on ready:
  - Next cycle valid=0 and all outputs at reset values.
  - start then begins a fresh write at BASE_ADDR.

Source files
------------

// File: rtl/mem_traffic_pkg.sv
// Shared types and the pattern formula for the memory write/readback traffic checker.
package mem_traffic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_REQ = 3'd1,
    ST_WR_GAP = 3'd2,
    ST_RD_REQ = 3'd3,
    ST_RD_GAP = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [7:0] PAT_LANE = 8'hA5;

  // One 32-bit lane of the test pattern; varies with pass, word index and lane.
  function automatic logic [31:0] pattern_lane(input logic [31:0] seed,
                                               input logic [7:0]  pass,
                                               input logic [7:0]  idx,
                                               input logic [7:0]  lane);
    return seed ^ {pass, idx, lane, PAT_LANE};
  endfunction

endpackage

// File: rtl/mem_pattern_gen.sv
// Combinational pattern word generator, shared by the write data path and the read compare.
module mem_pattern_gen
  import mem_traffic_pkg::*;
#(
  parameter int DATA_W = 256
) (
  input  logic [7:0]        idx,
  input  logic [7:0]        pass,
  input  logic [31:0]       seed,
  output logic [DATA_W-1:0] word
);

  for (genvar k = 0; k < DATA_W / 32; k++) begin : g_lane
    assign word[k*32 +: 32] = pattern_lane(seed, pass, idx, 8'(k));
  end

endmodule

// File: rtl/mem_traffic_checker.sv
// Write-then-readback traffic master: writes DEPTH pattern words, reads them back,
// and tracks mismatches, repeating with a new pattern on every pass.
module mem_traffic_checker
  import mem_traffic_pkg::*;
#(
  parameter int              DATA_W      = 256,
  parameter int              ADDR_W      = 28,
  parameter int              DEPTH       = 9,
  parameter int              CYCLE_DELAY = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 28'h0FF_1000,
  parameter int              ADDR_STRIDE = 8,
  parameter int              MAX_PASSES  = 0,
  parameter logic [31:0]     SEED        = 32'h800020C0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [DATA_W-1:0] mem_data_wr,
  input  logic [DATA_W-1:0] mem_data_rd,
  output logic [ADDR_W-1:0] mem_data_addr,
  output logic              mem_rw_data,
  output logic              mem_valid_data,
  input  logic              mem_ready_data,
  output logic              error,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [15:0]       pass_count,
  output logic              done
);

  state_t              state_q, state_d;
  state_t              pend_q, pend_d;
  logic [7:0]          idx_q, idx_d;
  logic [15:0]         pass_q, pass_d;
  logic [15:0]         gap_q, gap_d;
  logic                error_q, error_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic                valid_q, valid_d;
  logic                rw_q, rw_d;
  logic                done_q, done_d;

  logic [DATA_W-1:0]   pattern_s;
  logic [ADDR_W-1:0]   addr_s;
  logic                hs_s;
  logic                last_s;

  mem_pattern_gen #(.DATA_W(DATA_W)) u_pattern (
    .idx  (idx_q),
    .pass (pass_q[7:0]),
    .seed (SEED),
    .word (pattern_s)
  );

  assign addr_s = BASE_ADDR + ADDR_W'(idx_q) * ADDR_W'(ADDR_STRIDE);
  assign hs_s   = valid_q & mem_ready_data;
  assign last_s = (idx_q == 8'(DEPTH - 1));

  // Next-state, index, pass and mismatch bookkeeping.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    idx_d       = idx_q;
    pass_d      = pass_q;
    gap_d       = gap_q;
    error_d     = error_q;
    err_cnt_d   = err_cnt_q;
    fail_addr_d = fail_addr_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_WR_REQ;
          idx_d       = 8'd0;
          pass_d      = 16'd0;
          gap_d       = 16'd0;
          error_d     = 1'b0;
          err_cnt_d   = 16'd0;
          fail_addr_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      ST_WR_REQ: begin
        if (hs_s) begin
          idx_d  = last_s ? 8'd0 : idx_q + 8'd1;
          pend_d = last_s ? ST_RD_REQ : ST_WR_REQ;
          gap_d  = 16'd0;
          if (CYCLE_DELAY > 0) begin
            state_d = ST_WR_GAP;
          end else begin
            state_d = pend_d;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_RD_REQ: begin
        if (hs_s) begin
          if (mem_data_rd != pattern_s) begin
            error_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) begin
              err_cnt_d = err_cnt_q + 16'd1;
            end else begin
              err_cnt_d = err_cnt_q;
            end
            // Only the first mismatch of a run is recorded.
            if (err_cnt_q == 16'd0) begin
              fail_addr_d = addr_s;
            end else begin
              fail_addr_d = fail_addr_q;
            end
          end else begin
            error_d = error_q;
          end
          gap_d = 16'd0;
          if (last_s) begin
            idx_d  = 8'd0;
            pass_d = pass_q + 16'd1;
            pend_d = ST_WR_REQ;
          end else begin
            idx_d  = idx_q + 8'd1;
            pend_d = ST_RD_REQ;
          end
          if (last_s && (MAX_PASSES != 0) && (pass_d == 16'(MAX_PASSES))) begin
            state_d = ST_DONE;
          end else if (CYCLE_DELAY > 0) begin
            state_d = ST_RD_GAP;
          end else begin
            state_d = pend_d;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_WR_GAP, ST_RD_GAP: begin
        if (gap_q == 16'(CYCLE_DELAY - 1)) begin
          state_d = pend_q;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    valid_d = (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);
    rw_d    = (state_d == ST_WR_REQ);
    done_d  = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= ST_IDLE;
      idx_q       <= 8'd0;
      pass_q      <= 16'd0;
      gap_q       <= 16'd0;
      error_q     <= 1'b0;
      err_cnt_q   <= 16'd0;
      fail_addr_q <= '0;
      valid_q     <= 1'b0;
      rw_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      gap_q       <= gap_d;
      error_q     <= error_d;
      err_cnt_q   <= err_cnt_d;
      fail_addr_q <= fail_addr_d;
      valid_q     <= valid_d;
      rw_q        <= rw_d;
      done_q      <= done_d;
    end
  end

  assign mem_data_wr    = pattern_s;
  assign mem_data_addr  = addr_s;
  assign mem_rw_data    = rw_q;
  assign mem_valid_data = valid_q;
  assign error          = error_q;
  assign err_count      = err_cnt_q;
  assign fail_addr      = fail_addr_q;
  assign pass_count     = pass_q;
  assign done           = done_q;

endmodule

// File: tb/tb_mem_traffic_checker.sv
// Directed bench: a 3-pass soak with injected read corruption and reset while waiting
// on ready, plus a back-to-back, address-wrapping instance.
module tb_mem_traffic_checker;

  localparam logic [27:0] BASE_A = 28'h0FF1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: DEPTH 9, two idle cycles per command, stops after three passes.
  logic         rst_a, start_a, ready_a, corrupt_a;
  logic [255:0] wr_a, rd_a;
  logic [27:0]  addr_a, fail_a;
  logic         rw_a, valid_a, error_a, done_a;
  logic [15:0]  cnt_a, pass_a;
  logic [255:0] mem_a [0:15];
  logic [3:0]   midx_a;

  assign midx_a = 4'((addr_a - BASE_A) >> 3);
  assign rd_a   = mem_a[midx_a] ^ {255'd0, corrupt_a && (midx_a == 4'd4 || midx_a == 4'd6)};

  always @(posedge clk) begin
    if (valid_a && ready_a && rw_a) mem_a[midx_a] <= wr_a;
  end

  mem_traffic_checker #(
    .DATA_W(256), .ADDR_W(28), .DEPTH(9), .CYCLE_DELAY(2),
    .BASE_ADDR(28'h0FF1000), .ADDR_STRIDE(8), .MAX_PASSES(3), .SEED(32'h800020C0)
  ) u_dut_a (
    .clk(clk), .rst(rst_a), .start(start_a),
    .mem_data_wr(wr_a), .mem_data_rd(rd_a), .mem_data_addr(addr_a),
    .mem_rw_data(rw_a), .mem_valid_data(valid_a), .mem_ready_data(ready_a),
    .error(error_a), .err_count(cnt_a), .fail_addr(fail_a),
    .pass_count(pass_a), .done(done_a)
  );

  // Instance B: DEPTH 3, back-to-back commands, window wrapping past 2^28.
  logic         rst_b, start_b, ready_b;
  logic [63:0]  wr_b, rd_b;
  logic [27:0]  addr_b, fail_b;
  logic         rw_b, valid_b, error_b, done_b;
  logic [15:0]  cnt_b, pass_b;
  logic [63:0]  mem_b [0:3];

  assign rd_b = mem_b[addr_b[4:3]];

  always @(posedge clk) begin
    if (valid_b && ready_b && rw_b) mem_b[addr_b[4:3]] <= wr_b;
  end

  mem_traffic_checker #(
    .DATA_W(64), .ADDR_W(28), .DEPTH(3), .CYCLE_DELAY(0),
    .BASE_ADDR(28'hFFFFFF8), .ADDR_STRIDE(8), .MAX_PASSES(1), .SEED(32'h800020C0)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .start(start_b),
    .mem_data_wr(wr_b), .mem_data_rd(rd_b), .mem_data_addr(addr_b),
    .mem_rw_data(rw_b), .mem_valid_data(valid_b), .mem_ready_data(ready_b),
    .error(error_b), .err_count(cnt_b), .fail_addr(fail_b),
    .pass_count(pass_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] lane0_exp [0:2];
  logic [27:0] addr_b_exp [0:4];
  logic        rw_b_exp [0:4];
  int          exp_cnt;

  initial begin
    lane0_exp  = '{32'h80002065, 32'h81002065, 32'h82002065};
    addr_b_exp = '{28'h0000000, 28'h0000008, 28'hFFFFFF8, 28'h0000000, 28'h0000008};
    rw_b_exp   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) mem_a[i] = 256'd0;
    for (int i = 0; i < 4; i++) mem_b[i] = 64'd0;
    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    ready_a = 1'b1; ready_b = 1'b0; corrupt_a = 1'b0;
    exp_cnt = 0;
    step(); step();
    rst_a = 1'b0; rst_b = 1'b0;
    step();

    chk("a_rst_valid", valid_a, 1'b0);
    chk("a_rst_rw", rw_a, 1'b0);
    chk("a_rst_addr", addr_a, 28'h0FF1000);
    chk("a_rst_lane0", wr_a[31:0], 32'h80002065);
    chk("a_rst_lane7", wr_a[255:224], 32'h80002765);
    chk("a_rst_error", error_a, 1'b0);
    chk("a_rst_cnt", cnt_a, 16'd0);
    chk("a_rst_fail", fail_a, 28'd0);
    chk("a_rst_pass", pass_a, 16'd0);
    chk("a_rst_done", done_a, 1'b0);
    chk("b_rst_valid", valid_b, 1'b0);
    chk("b_rst_addr", addr_b, 28'hFFFFFF8);
    chk("b_rst_lane0", wr_b[31:0], 32'h80002065);

    start_a = 1'b1;
    step();
    start_a = 1'b0;

    for (int p = 0; p < 3; p++) begin
      corrupt_a = (p == 1);
      for (int i = 0; i < 9; i++) begin
        chk("a_wr_valid", valid_a, 1'b1);
        chk("a_wr_rw", rw_a, 1'b1);
        chk("a_wr_addr", addr_a, 28'h0FF1000 + 28'(i * 8));
        if (i == 0) chk("a_wr_lane0", wr_a[31:0], lane0_exp[p]);
        step();
        chk("a_wgap1_valid", valid_a, 1'b0);
        step();
        chk("a_wgap2_valid", valid_a, 1'b0);
        step();
      end
      for (int i = 0; i < 9; i++) begin
        chk("a_rd_valid", valid_a, 1'b1);
        chk("a_rd_rw", rw_a, 1'b0);
        chk("a_rd_addr", addr_a, 28'h0FF1000 + 28'(i * 8));
        if (p == 1 && (i == 4 || i == 6)) exp_cnt++;
        step();
        chk("a_error", error_a, exp_cnt != 0);
        chk("a_err_count", cnt_a, 16'(exp_cnt));
        chk("a_fail_addr", fail_a, (exp_cnt != 0) ? 28'h0FF1020 : 28'd0);
        if (i == 8) chk("a_pass_count", pass_a, 16'(p + 1));
        if (p == 2 && i == 8) begin
          chk("a_done_rise", done_a, 1'b1);
          chk("a_done_valid", valid_a, 1'b0);
        end else begin
          chk("a_rgap_done", done_a, 1'b0);
          chk("a_rgap1_valid", valid_a, 1'b0);
          step();
          chk("a_rgap2_valid", valid_a, 1'b0);
          step();
        end
      end
    end
    corrupt_a = 1'b0;
    step();
    chk("a_done_hold", done_a, 1'b1);
    chk("a_done_hold_valid", valid_a, 1'b0);

    // Restart from DONE clears the run statistics.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("a_restart_error", error_a, 1'b0);
    chk("a_restart_cnt", cnt_a, 16'd0);
    chk("a_restart_fail", fail_a, 28'd0);
    chk("a_restart_pass", pass_a, 16'd0);
    chk("a_restart_done", done_a, 1'b0);
    chk("a_restart_valid", valid_a, 1'b1);
    chk("a_restart_addr", addr_a, 28'h0FF1000);
    for (int s = 0; s < 26; s++) step();
    ready_a = 1'b0;
    step();
    for (int c = 0; c < 4; c++) begin
      chk("a_rdwait_valid", valid_a, 1'b1);
      chk("a_rdwait_rw", rw_a, 1'b0);
      chk("a_rdwait_addr", addr_a, 28'h0FF1000);
      step();
    end
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    chk("a_mrst_valid", valid_a, 1'b0);
    chk("a_mrst_rw", rw_a, 1'b0);
    chk("a_mrst_addr", addr_a, 28'h0FF1000);
    chk("a_mrst_lane0", wr_a[31:0], 32'h80002065);
    chk("a_mrst_error", error_a, 1'b0);
    chk("a_mrst_cnt", cnt_a, 16'd0);
    chk("a_mrst_pass", pass_a, 16'd0);
    chk("a_mrst_done", done_a, 1'b0);
    ready_a = 1'b1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("a_fresh_valid", valid_a, 1'b1);
    chk("a_fresh_rw", rw_a, 1'b1);
    chk("a_fresh_addr", addr_a, 28'h0FF1000);

    // Instance B: command held while ready is low, then back-to-back traffic.
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("b_hold_valid", valid_b, 1'b1);
      chk("b_hold_rw", rw_b, 1'b1);
      chk("b_hold_addr", addr_b, 28'hFFFFFF8);
      chk("b_hold_lane0", wr_b[31:0], 32'h80002065);
      step();
    end
    chk("b_hold6_valid", valid_b, 1'b1);
    ready_b = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("b_b2b_valid", valid_b, 1'b1);
      chk("b_b2b_rw", rw_b, rw_b_exp[i]);
      chk("b_b2b_addr", addr_b, addr_b_exp[i]);
      step();
    end
    chk("b_done", done_b, 1'b1);
    chk("b_done_valid", valid_b, 1'b0);
    chk("b_pass", pass_b, 16'd1);
    chk("b_error", error_b, 1'b0);
    chk("b_cnt", cnt_b, 16'd0);
    chk("b_fail", fail_b, 28'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
